// File: rtl/sand_vga_raster.sv
// sand_vga_raster
// VGA raster generator fed by the sand_top register block. It produces
// 640x480@60Hz timing (one pixel tick every second clk) and a per-pixel colour:
// a solid background with a square ball drawn on top. The colour and ball
// inputs are copied into shadow registers once per frame, at the end of the
// last active line, so a frame is never drawn with a mix of old and new values.
//
// Ports
//   clk                      system clock (50 MHz)
//   reset                    asynchronous, active-high
//   background_r/g/b [7:0]   background colour
//   ball_x/ball_y    [7:0]   ball position, coarse units (pixel = pos << POS_SHIFT)
//   vga_r/g/b        [7:0]   pixel colour, zero while blanked
//   vga_hs, vga_vs           syncs, active low
//   vga_blank_n              high during active video
//   vga_sync_n               tied low
//   vga_clk                  25 MHz pixel clock (~pix_en)
//   frame_done               one-clk pulse when the shadows are loaded
module sand_vga_raster #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          BALL_SIZE = 16,
    parameter int          POS_SHIFT = 1,
    parameter logic [23:0] BALL_RGB  = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] background_r,
    input  logic [7:0] background_g,
    input  logic [7:0] background_b,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ACT_L   = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT_L   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);

    logic        pix_en_q;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [7:0]  bg_r_q, bg_g_q, bg_b_q;
    logic [7:0]  ball_x_q, ball_y_q;
    logic [7:0]  r_q, g_q, b_q;
    logic        hs_q, vs_q, blank_n_q;

    logic        frame_end;
    logic        blank_n_d, hs_d, vs_d, hit;
    logic [10:0] bx, by, hx, vy;
    logic [23:0] rgb_d;

    // Raster position advance
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
    end

    assign frame_end = (hcount_q == H_LAST) && (vcount_q == V_ACT_END);

    // Pixel function of the current position and the shadow registers
    always_comb begin
        blank_n_d = (hcount_q < H_ACT_L) && (vcount_q < V_ACT_L);
        hs_d      = !((hcount_q >= HS_START) && (hcount_q < HS_END));
        vs_d      = !((vcount_q >= VS_START) && (vcount_q < VS_END));
        // 11-bit arithmetic so bx+BALL_SIZE never wraps; off-screen parts just fail the test
        bx        = 11'(ball_x_q) << POS_SHIFT;
        by        = 11'(ball_y_q) << POS_SHIFT;
        hx        = {1'b0, hcount_q};
        vy        = {1'b0, vcount_q};
        hit       = (hx >= bx) && (hx < bx + BALL_W) && (vy >= by) && (vy < by + BALL_W);
        rgb_d     = '0;
        if (blank_n_d) begin
            rgb_d = hit ? BALL_RGB : {bg_r_q, bg_g_q, bg_b_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en_q  <= 1'b0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            bg_r_q    <= 8'h00;
            bg_g_q    <= 8'h40;
            bg_b_q    <= 8'h80;
            ball_x_q  <= 8'h04;
            ball_y_q  <= 8'h04;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                hcount_q  <= hcount_d;
                vcount_q  <= vcount_d;
                r_q       <= rgb_d[23:16];
                g_q       <= rgb_d[15:8];
                b_q       <= rgb_d[7:0];
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= blank_n_d;
                // Shadows change only inside vertical blanking
                if (frame_end) begin
                    bg_r_q   <= background_r;
                    bg_g_q   <= background_g;
                    bg_b_q   <= background_b;
                    ball_x_q <= ball_x;
                    ball_y_q <= ball_y;
                end
            end
        end
    end

    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = ~pix_en_q;
    assign frame_done  = pix_en_q && frame_end;

endmodule

// File: tb/tb_sand_vga_raster.sv
// Bench for sand_vga_raster. Two instances share clock, reset and inputs:
// index 0 uses a shrunken raster (80x67 total) so several whole frames fit in
// a short run; index 1 uses the default 800x525 raster. The reference model
// derives every expected output from the tick count since reset release.
module tb_sand_vga_raster;

    localparam int HA  [2] = '{64, 640};
    localparam int HFP [2] = '{4, 16};
    localparam int HSW [2] = '{8, 96};
    localparam int HBP [2] = '{4, 48};
    localparam int VA  [2] = '{60, 480};
    localparam int VFP [2] = '{2, 10};
    localparam int VSW [2] = '{2, 2};
    localparam int VBP [2] = '{3, 33};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bg_r, bg_g, bg_b, ball_x, ball_y;

    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       hs0, vs0, bn0, sn0, vc0, fd0;
    logic       hs1, vs1, bn1, sn1, vc1, fd1;
    logic [29:0] obs [2];

    int tests = 0;
    int fails = 0;
    int n;                       // ticks since reset release
    logic [7:0] sh [2][5];       // model shadows: r,g,b,x,y
    int blank_cnt, ball_cnt, hs_low_cnt;

    always #10 clk = ~clk;

    sand_vga_raster #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .reset(reset),
        .background_r(bg_r), .background_g(bg_g), .background_b(bg_b),
        .ball_x(ball_x), .ball_y(ball_y),
        .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bn0), .vga_sync_n(sn0),
        .vga_clk(vc0), .frame_done(fd0)
    );

    sand_vga_raster dut_f (
        .clk(clk), .reset(reset),
        .background_r(bg_r), .background_g(bg_g), .background_b(bg_b),
        .ball_x(ball_x), .ball_y(ball_y),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bn1), .vga_sync_n(sn1),
        .vga_clk(vc1), .frame_done(fd1)
    );

    assign obs[0] = {r0, g0, b0, hs0, vs0, bn0, sn0, vc0, fd0};
    assign obs[1] = {r1, g1, b1, hs1, vs1, bn1, sn1, vc1, fd1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sh_reset();
        for (int d = 0; d < 2; d++) begin
            sh[d][0] = 8'h00; sh[d][1] = 8'h40; sh[d][2] = 8'h80;
            sh[d][3] = 8'h04; sh[d][4] = 8'h04;
        end
    endtask

    task automatic randomize_inputs();
        bg_r   = 8'($urandom);
        bg_g   = 8'($urandom);
        bg_b   = 8'($urandom);
        ball_x = 8'($urandom);
        ball_y = 8'($urandom);
    endtask

    function automatic int htot(input int d);
        return HA[d] + HFP[d] + HSW[d] + HBP[d];
    endfunction

    function automatic int vtot(input int d);
        return VA[d] + VFP[d] + VSW[d] + VBP[d];
    endfunction

    // Expected colour at (h,v) from the model shadows
    function automatic logic [23:0] exp_rgb(input int d, input int h, input int v);
        int bx, by;
        if (!(h < HA[d] && v < VA[d])) return 24'h0;
        bx = int'(sh[d][3]) * 2;
        by = int'(sh[d][4]) * 2;
        if (h >= bx && h < bx + 16 && v >= by && v < by + 16) return 24'hFFFFFF;
        return {sh[d][0], sh[d][1], sh[d][2]};
    endfunction

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_rgb%0d", tag, d), 32'(obs[d][29:6]), 32'h0);
            // hs=1 vs=1 blank_n=0 sync_n=0 vga_clk=1 frame_done=0
            chk($sformatf("%s_ctl%0d", tag, d), 32'(obs[d][5:0]), 32'b110010);
        end
    endtask

    // One pixel tick: check the clk where pix_en is high, then the registered outputs.
    task automatic step();
        int h, v, p;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            p = n % (htot(d) * vtot(d));
            h = p % htot(d);
            v = p / htot(d);
            chk($sformatf("fdone%0d_n%0d", d, n), 32'(obs[d][0]),
                32'(h == htot(d) - 1 && v == VA[d] - 1));
            chk($sformatf("vclk%0d_n%0d", d, n), 32'(obs[d][1]), 32'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            logic ehs, evs, ebn;
            p   = n % (htot(d) * vtot(d));
            h   = p % htot(d);
            v   = p / htot(d);
            ehs = !(h >= HA[d] + HFP[d] && h < HA[d] + HFP[d] + HSW[d]);
            evs = !(v >= VA[d] + VFP[d] && v < VA[d] + VFP[d] + VSW[d]);
            ebn = (h < HA[d]) && (v < VA[d]);
            chk($sformatf("rgb%0d_h%0d_v%0d", d, h, v), 32'(obs[d][29:6]), 32'(exp_rgb(d, h, v)));
            chk($sformatf("sync%0d_h%0d_v%0d", d, h, v), 32'(obs[d][5:1]),
                32'({ehs, evs, ebn, 1'b0, 1'b1}));
            if (d == 0) begin
                if (obs[0][3]) blank_cnt++;
                if (obs[0][3] && obs[0][29:6] == 24'hFFFFFF) ball_cnt++;
            end
            if (d == 1 && n < 800 && !obs[1][5]) hs_low_cnt++;
            if (h == htot(d) - 1 && v == VA[d] - 1) begin
                sh[d][0] = bg_r; sh[d][1] = bg_g; sh[d][2] = bg_b;
                sh[d][3] = ball_x; sh[d][4] = ball_y;
            end
        end
        n++;
    endtask

    initial begin
        int ft, load_k;
        ft     = 80 * 67;
        load_k = 59 * 80 + 79;
        reset  = 1'b1;
        randomize_inputs();
        sh_reset();
        n = 0;
        hs_low_cnt = 0;

        // Reset held: outputs at reset values
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        @(negedge clk);
        reset = 1'b0;

        // Three frames of the small raster; inputs change every tick but only
        // the values present at the load tick may show up in the next frame.
        for (int f = 0; f < 3; f++) begin
            blank_cnt = 0;
            ball_cnt  = 0;
            for (int k = 0; k < ft; k++) begin
                randomize_inputs();
                if (k == load_k) begin
                    bg_r = bg_r & 8'h7F;
                    if (f == 0) begin
                        ball_x = 8'd10; ball_y = 8'd20;
                    end else if (f == 1) begin
                        ball_x = 8'd255; ball_y = 8'd255;
                    end
                end
                step();
            end
            chk($sformatf("blank_cnt_f%0d", f), 32'(blank_cnt), 32'(64 * 60));
            chk($sformatf("ball_cnt_f%0d", f), 32'(ball_cnt), (f == 2) ? 32'd0 : 32'd256);
        end
        chk("hs_low_line0", 32'(hs_low_cnt), 32'd96);

        // Run the full raster to hcount 300, then reset mid-line
        for (int k = 0; k < 800; k++) begin
            if ((n % 800) == 300) break;
            randomize_inputs();
            step();
        end
        chk("mid_h300", 32'(n % 800), 32'd300);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        sh_reset();
        hs_low_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            randomize_inputs();
            step();
        end
        chk("hs_low_after_rst", 32'(hs_low_cnt), 32'd96);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
